cmplx_mult_pipe: RTL and testbench

Parametrised, fully pipelined signed complex multiplier with valid/ready handshakes on the operand and result sides. It supersedes the fixed single-product datapath. New in this generation: configurable pipeline depth, a per-transaction conjugate mode, bubble-collapsing backpressure and a synchronous software reset. It sits between the operand source agent (op_*) and the result sink agent (res_*).

---
 rtl/cmplx_mult_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_cmplx_mult_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_mult_pipe.sv
// Pipelined signed complex multiplier with valid/ready handshakes and a per-transaction conjugate mode.
// Optional performance counters are enabled with `define CMPLX_MULT_PERF_CNT_EN.
module cmplx_mult_pipe #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_rst,
  input  logic                  op_val,
  output logic                  op_rdy,
  input  logic                  op_conj,
  input  logic [4*DWIDTH-1:0]   op_data,
  output logic                  res_val,
  input  logic                  res_rdy,
`ifdef CMPLX_MULT_PERF_CNT_EN
  output logic [4*DWIDTH+3:0]   res_data,
  output logic [31:0]           perf_ops,
  output logic [31:0]           perf_stall
`else
  output logic [4*DWIDTH+3:0]   res_data
`endif
);

  localparam int unsigned PW  = 2 * DWIDTH;
  localparam int unsigned RW  = 2 * DWIDTH + 2;
  localparam int unsigned PPW = 4 * PW + 1;

  function automatic logic [PW-1:0] sext_op(input logic [DWIDTH-1:0] x);
    return {{DWIDTH{x[DWIDTH-1]}}, x};
  endfunction

  function automatic logic [RW-1:0] sext_pp(input logic [PW-1:0] x);
    return {{2{x[PW-1]}}, x};
  endfunction

  // Partial products are packed as {conj, a_im*b_re, a_re*b_im, a_im*b_im, a_re*b_re}.
  function automatic logic [2*RW-1:0] combine(input logic [PPW-1:0] pp);
    logic [RW-1:0] rr;
    logic [RW-1:0] ii;
    logic [RW-1:0] ri;
    logic [RW-1:0] ir;
    logic [RW-1:0] re;
    logic [RW-1:0] im;
    rr = sext_pp(pp[PW-1:0]);
    ii = sext_pp(pp[2*PW-1:PW]);
    ri = sext_pp(pp[3*PW-1:2*PW]);
    ir = sext_pp(pp[4*PW-1:3*PW]);
    if (pp[PPW-1]) begin
      re = rr + ii;
      im = ir - ri;
    end else begin
      re = rr - ii;
      im = ri + ir;
    end
    return {im, re};
  endfunction

  logic [DWIDTH-1:0] a_re;
  logic [DWIDTH-1:0] a_im;
  logic [DWIDTH-1:0] b_re;
  logic [DWIDTH-1:0] b_im;
  logic [PPW-1:0]    pp_in;

  assign a_re = op_data[DWIDTH-1:0];
  assign a_im = op_data[2*DWIDTH-1:DWIDTH];
  assign b_re = op_data[3*DWIDTH-1:2*DWIDTH];
  assign b_im = op_data[4*DWIDTH-1:3*DWIDTH];

  // Products of sign-extended operands are exact in PW bits, so unsigned multiply suffices.
  assign pp_in = {op_conj,
                  sext_op(a_im) * sext_op(b_re),
                  sext_op(a_re) * sext_op(b_im),
                  sext_op(a_im) * sext_op(b_im),
                  sext_op(a_re) * sext_op(b_re)};

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_up;
  logic [STAGES-1:0] load;
  logic              init_done;
  logic              accept;

  // Load chain from the output back to stage 0; an empty stage always loads.
  always_comb begin
    logic ld;
    load = '0;
    ld   = !v[STAGES-1] || res_rdy;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ld = !v[STAGES-1-k] || ld;
      load[STAGES-1-k] = ld;
    end
  end

  assign op_rdy  = init_done && !sw_rst && load[0];
  assign accept  = op_val && op_rdy;
  assign res_val = v[STAGES-1];

  always_comb begin
    v_up    = '0;
    v_up[0] = accept;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_up[k] = v[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (sw_rst) begin
      v <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v[k] <= v_up[k];
        end
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      logic [2*RW-1:0] res_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= '0;
        end else if (sw_rst) begin
          res_q <= '0;
        end else if (accept) begin
          res_q <= combine(pp_in);
        end
      end

      assign res_data = res_q;
    end else begin : g_multi
      // Stage 0 holds partial products; stage 1 forms the sums; later stages are plain delay.
      logic [PPW-1:0]  pp_q;
      logic [2*RW-1:0] dat_q  [1:STAGES-1];
      logic [2*RW-1:0] dat_up [1:STAGES-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pp_q <= '0;
        end else if (sw_rst) begin
          pp_q <= '0;
        end else if (accept) begin
          pp_q <= pp_in;
        end
      end

      always_comb begin
        dat_up[1] = combine(pp_q);
        for (int unsigned k = 2; k < STAGES; k++) begin
          dat_up[k] = dat_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned k = 1; k < STAGES; k++) begin
            dat_q[k] <= '0;
          end
        end else if (sw_rst) begin
          for (int unsigned k = 1; k < STAGES; k++) begin
            dat_q[k] <= '0;
          end
        end else begin
          for (int unsigned k = 1; k < STAGES; k++) begin
            if (load[k] && v_up[k]) begin
              dat_q[k] <= dat_up[k];
            end
          end
        end
      end

      assign res_data = dat_q[STAGES-1];
    end
  endgenerate

`ifdef CMPLX_MULT_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else if (sw_rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept && (perf_ops != '1)) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (res_val && !res_rdy && (perf_stall != '1)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// Self-checking bench for cmplx_mult_pipe: directed vector table, latency/backpressure/reset
// sequences, and randomized traffic scored against an integer-arithmetic reference queue.
module tb_cmplx_mult_pipe;

  localparam int DW = 8;
  localparam int ST = 3;
  localparam int RW = 2 * DW + 2;

  logic              clk;
  logic              rst_n;
  logic              sw_rst;
  logic              op_val;
  logic              op_rdy;
  logic              op_conj;
  logic [4*DW-1:0]   op_data;
  logic              res_val;
  logic              res_rdy;
  logic [2*RW-1:0]   res_data;
`ifdef CMPLX_MULT_PERF_CNT_EN
  logic [31:0]       perf_ops;
  logic [31:0]       perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  logic [2*RW-1:0] q [$];
  bit              prev_stall;
  logic [2*RW-1:0] prev_data;

  typedef struct {
    logic [7:0] ar;
    logic [7:0] ai;
    logic [7:0] br;
    logic [7:0] bi;
    logic       conj;
    int         re;
    int         im;
  } vec_t;

  vec_t vecs [6];

  cmplx_mult_pipe #(.DWIDTH(DW), .STAGES(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_rst    (sw_rst),
    .op_val    (op_val),
    .op_rdy    (op_rdy),
    .op_conj   (op_conj),
    .op_data   (op_data),
    .res_val   (res_val),
    .res_rdy   (res_rdy),
`ifdef CMPLX_MULT_PERF_CNT_EN
    .res_data  (res_data),
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall)
`else
    .res_data  (res_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [2*RW-1:0] pack(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {i[RW-1:0], r[RW-1:0]};
  endfunction

  function automatic logic [2*RW-1:0] ref_mult(input logic [4*DW-1:0] d, input logic c);
    int ar, ai, br, bi, re, im;
    ar = int'($signed(d[DW-1:0]));
    ai = int'($signed(d[2*DW-1:DW]));
    br = int'($signed(d[3*DW-1:2*DW]));
    bi = int'($signed(d[4*DW-1:3*DW]));
    if (c) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    return pack(re, im);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard: every accepted operand queues its expected product; every emitted result pops one.
  always @(negedge clk) begin
    if (!rst_n || sw_rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && res_val) chk("res_hold", res_data, prev_data);
      if (res_val && res_rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: got %0h expected no result at %0t", res_data, $time);
        end else begin
          chk("res_data", res_data, q.pop_front());
        end
      end
      if (op_val && op_rdy) q.push_back(ref_mult(op_data, op_conj));
      prev_stall = res_val && !res_rdy;
      prev_data  = res_data;
    end
  end

  task automatic rand_op();
    logic [7:0] e;
    op_data = $urandom;
    op_conj = 1'($urandom_range(1));
    if ($urandom_range(7) == 0) begin
      e = ($urandom_range(1) == 0) ? 8'h80 : 8'h7F;
      op_data = {e, e, e, e};
    end
  endtask

  // One cycle of a well-behaved source/sink: hold the operand until it is taken.
  task automatic step(input bit want, input bit rdy);
    bit xfer;
    @(negedge clk);
    xfer = op_val && op_rdy;
    if (xfer) n_acc++;
    @(posedge clk);
    #1;
    res_rdy = rdy;
    if (!op_val || xfer) begin
      op_val = want;
      if (want) rand_op();
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      step(1'b0, 1'b1);
      if (!op_val && !res_val && q.size() == 0) done = 1'b1;
    end
    chk("drain_done", done, 1);
  endtask

  // Expects op_val=1 with the operand presented; checks acceptance and exact latency.
  task automatic check_latency(input logic [2*RW-1:0] exp, input bit post_rst);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (post_rst && i == 0) begin
        chk("rst_res_val", res_val, 0);
        chk("rst_res_data", res_data, 0);
`ifdef CMPLX_MULT_PERF_CNT_EN
        chk("rst_perf_ops", perf_ops, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
      end
      if (op_rdy) ok = 1'b1;
    end
    chk("accept_wait", ok, 1);
    @(posedge clk);
    #1;
    op_val = 1'b0;
    for (int i = 0; i < ST - 1; i++) begin
      @(negedge clk);
      chk("latency_early", res_val, 0);
    end
    @(negedge clk);
    chk("latency_valid", res_val, 1);
    chk("latency_data", res_data, exp);
  endtask

  initial begin
    vecs[0] = '{ar:8'd3,   ai:8'd4,   br:8'd1,   bi:8'd2,   conj:1'b0, re:-5,     im:10};
    vecs[1] = '{ar:8'd3,   ai:8'd4,   br:8'd1,   bi:8'd2,   conj:1'b1, re:11,     im:-2};
    vecs[2] = '{ar:8'h80,  ai:8'h80,  br:8'h80,  bi:8'h80,  conj:1'b1, re:32768,  im:0};
    vecs[3] = '{ar:8'h80,  ai:8'h80,  br:8'h80,  bi:8'h80,  conj:1'b0, re:0,      im:32768};
    vecs[4] = '{ar:8'h7F,  ai:8'h7F,  br:8'h80,  bi:8'h7F,  conj:1'b0, re:-32385, im:-127};
    vecs[5] = '{ar:8'd1,   ai:8'd0,   br:8'd5,   bi:8'hF9,  conj:1'b1, re:5,      im:7};

    rst_n   = 1'b0;
    sw_rst  = 1'b0;
    op_val  = 1'b0;
    op_conj = 1'b0;
    op_data = '0;
    res_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_op_rdy", op_rdy, 0);
    chk("reset_res_val", res_val, 0);
    chk("reset_res_data", res_data, 0);
`ifdef CMPLX_MULT_PERF_CNT_EN
    chk("reset_perf_ops", perf_ops, 0);
    chk("reset_perf_stall", perf_stall, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      op_val  = 1'b1;
      op_conj = vecs[i].conj;
      op_data = {vecs[i].bi, vecs[i].br, vecs[i].ai, vecs[i].ar};
      res_rdy = 1'b1;
      check_latency(pack(vecs[i].re, vecs[i].im), 1'b0);
    end
    drain();

    // Back-to-back streaming with the sink always ready.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk);
          #1;
          op_val = 1'b1;
          rand_op();
          @(negedge clk);
          chk("b2b_op_rdy", op_rdy, 1);
        end
        @(posedge clk);
        #1;
        op_val = 1'b0;
      end
      begin
        int run, maxrun, total;
        run = 0;
        maxrun = 0;
        total = 0;
        for (int i = 0; i < 16; i++) begin
          @(negedge clk);
          if (res_val) begin
            run++;
            total++;
            if (run > maxrun) maxrun = run;
          end else begin
            run = 0;
          end
        end
        chk("b2b_total", total, 8);
        chk("b2b_run", maxrun, 8);
      end
    join
    drain();

    // Backpressure: fill the pipe, then open a bubble and let it collapse.
    n_acc = 0;
    repeat (6) step(1'b1, 1'b0);
    chk("bp_accepts", n_acc, ST);
    @(negedge clk);
    chk("bp_full_rdy", op_rdy, 0);
    chk("bp_full_val", res_val, 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clk);
    chk("bubble_rdy", op_rdy, 1);
    repeat (4) step(1'b1, 1'b1);
    drain();

    repeat (300) step($urandom_range(3) != 0, $urandom_range(2) != 0);
    drain();

    // Asynchronous reset with transactions in flight and an operand pending.
    repeat (4) step(1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("arst_op_rdy", op_rdy, 0);
    chk("arst_res_val", res_val, 0);
    chk("arst_res_data", res_data, 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    res_rdy = 1'b1;
    check_latency(ref_mult(op_data, op_conj), 1'b1);
`ifdef CMPLX_MULT_PERF_CNT_EN
    chk("arst_perf_ops", perf_ops, 1);
    chk("arst_perf_stall", perf_stall, 0);
`endif

    // Synchronous reset with transactions in flight and an operand pending.
    repeat (4) step(1'b1, 1'b0);
    sw_rst = 1'b1;
    @(negedge clk);
    chk("swrst_op_rdy", op_rdy, 0);
    @(posedge clk);
    #1;
    sw_rst  = 1'b0;
    res_rdy = 1'b1;
    check_latency(ref_mult(op_data, op_conj), 1'b1);
`ifdef CMPLX_MULT_PERF_CNT_EN
    chk("swrst_perf_ops", perf_ops, 1);
    chk("swrst_perf_stall", perf_stall, 0);
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
